// File: rtl/stopwatch_count_ctrl.sv
// stopwatch_count_ctrl
//
// Control core of a stopwatch with a bounded 14-bit count. A prescaler turns
// the system clock into count steps; an FSM (IDLE/RUN/PAUSE/DONE) reacts to
// rising edges of the debounced start and clear buttons. The +1/-1 arithmetic
// and the reload value live upstream: this block only selects when to take
// next_val or load_val and keeps the result inside 0..LIMIT_HI.
//
// Parameters
//   TICK_DIV  clock cycles per count step (>= 2)
//   LIMIT_HI  upper count bound
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start_btn  in   debounced level, rising edge = start/stop request
//   clear_btn  in   debounced level, rising edge = reload request
//   mode       in   [1:0] 00 up/0, 01 up/switches, 10 down/9999, 11 down/switches
//   next_val   in   [13:0] upstream count+1 or count-1
//   load_val   in   [13:0] upstream reload value
//   count      out  [13:0] registered count
//   running    out  high while in RUN
//   at_limit   out  high while in DONE
//   tick       out  one-cycle pulse on each prescaler wrap in RUN

module stopwatch_count_ctrl #(
    parameter int TICK_DIV = 1000000,
    parameter int LIMIT_HI = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        clear_btn,
    input  logic [1:0]  mode,
    input  logic [13:0] next_val,
    input  logic [13:0] load_val,
    output logic [13:0] count,
    output logic        running,
    output logic        at_limit,
    output logic        tick
);

    localparam int              PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [13:0]     LIM        = 14'(LIMIT_HI);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic [13:0]   count_next;
    logic          tick_next;

    logic          start_q;
    logic          clear_q;
    logic          armed;
    logic          start_edge;
    logic          clear_edge;

    logic [13:0]   limit;
    logic [13:0]   load_clamped;
    logic [13:0]   step_val;

    // armed stays low for the first cycle after reset so that a button held
    // high through reset release is captured into start_q/clear_q without
    // being seen as a fresh press.
    assign start_edge = armed & start_btn & ~start_q;
    assign clear_edge = armed & clear_btn & ~clear_q;

    // Up-counting modes stop at LIMIT_HI, down-counting modes stop at 0.
    assign limit = mode[1] ? 14'd0 : LIM;

    // Clamp both upstream operands so count can never leave 0..LIMIT_HI,
    // whatever the switches or the upstream mux present.
    assign load_clamped = (load_val > LIM) ? LIM : load_val;
    assign step_val     = (next_val > LIM) ? LIM : next_val;

    // Next-state logic. A clear press wins over everything else in the same
    // cycle; otherwise each state handles start presses and, in RUN, the
    // prescaler wrap that produces a count step.
    always_comb begin
        state_next = state;
        count_next = count;
        presc_next = presc;
        tick_next  = 1'b0;

        if (clear_edge) begin
            state_next = IDLE;
            count_next = load_clamped;
            presc_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        presc_next = '0;
                        state_next = (count == limit) ? DONE : RUN;
                    end
                end
                PAUSE: begin
                    // Prescaler is left where the pause froze it so that the
                    // interrupted step resumes rather than restarts.
                    if (start_edge) begin
                        state_next = (count == limit) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (start_edge) begin
                        state_next = PAUSE;
                    end else if (presc == PRESC_LAST) begin
                        presc_next = '0;
                        tick_next  = 1'b1;
                        if (count == limit) begin
                            state_next = DONE;
                        end else begin
                            count_next = step_val;
                            if (step_val == limit) begin
                                state_next = DONE;
                            end
                        end
                    end else begin
                        presc_next = presc + 1'b1;
                    end
                end
                DONE: begin
                    state_next = DONE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State and output registers. running/at_limit are decoded from the next
    // state so they change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            presc    <= '0;
            tick     <= 1'b0;
            running  <= 1'b0;
            at_limit <= 1'b0;
            start_q  <= 1'b0;
            clear_q  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            presc    <= presc_next;
            tick     <= tick_next;
            running  <= (state_next == RUN);
            at_limit <= (state_next == DONE);
            start_q  <= start_btn;
            clear_q  <= clear_btn;
            armed    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_stopwatch_count_ctrl.sv
// tb_stopwatch_count_ctrl
//
// Bench for stopwatch_count_ctrl with TICK_DIV=4. Each test task builds a
// per-cycle plan of inputs and expected outputs, pushes the expectation onto a
// scoreboard as the inputs are driven, and pops/compares it one cycle later.
// next_val is produced here the way the upstream +1/-1 mux would produce it.

module tb_stopwatch_count_ctrl;

    localparam int TICK_DIV = 4;
    localparam int LIMIT_HI = 9999;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_btn;
    logic        clear_btn;
    logic [1:0]  mode;
    logic [13:0] next_val;
    logic [13:0] load_val;
    logic [13:0] count;
    logic        running;
    logic        at_limit;
    logic        tick;

    typedef struct {
        logic        r;
        logic        s;
        logic        c;
        logic [1:0]  m;
        logic [13:0] ld;
        logic [16:0] exp;
    } stim_t;

    stim_t       plan[$];
    logic [16:0] sb[$];
    logic [16:0] e;
    logic [16:0] obs;
    int          cmp_count  = 0;
    int          fail_count = 0;

    stopwatch_count_ctrl #(
        .TICK_DIV (TICK_DIV),
        .LIMIT_HI (LIMIT_HI)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_btn (start_btn),
        .clear_btn (clear_btn),
        .mode      (mode),
        .next_val  (next_val),
        .load_val  (load_val),
        .count     (count),
        .running   (running),
        .at_limit  (at_limit),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    // Upstream model: +1 in up modes, -1 in down modes, combinational from count.
    assign next_val = mode[1] ? (count - 14'd1) : (count + 14'd1);

    // Append n identical cycles to the plan: inputs for the cycle and the
    // outputs expected right after its rising edge.
    task automatic add(input int n, input bit r, input bit s, input bit c,
                       input logic [1:0] m, input int ld,
                       input int cnt, input bit run, input bit lim, input bit tk);
        stim_t st;
        st.r   = r;
        st.s   = s;
        st.c   = c;
        st.m   = m;
        st.ld  = 14'(ld);
        st.exp = {14'(cnt), run, lim, tk};
        for (int i = 0; i < n; i++) plan.push_back(st);
    endtask

    task automatic test_reset();
        plan.delete();
        add(2, 1, 0, 0, 2'b00, 0,    0, 0, 0, 0);
        add(1, 0, 0, 0, 2'b00, 0,    0, 0, 0, 0);
        foreach (plan[i]) begin
            rst = plan[i].r; start_btn = plan[i].s; clear_btn = plan[i].c;
            mode = plan[i].m; load_val = plan[i].ld;
            sb.push_back(plan[i].exp);
            @(posedge clk); #1;
            e = sb.pop_front();
            obs = {count, running, at_limit, tick};
            cmp_count++;
            if (obs !== e) begin
                fail_count++;
                $display("[TB] FAIL reset step %0d: got count=%0d running=%b at_limit=%b tick=%b, expected count=%0d running=%b at_limit=%b tick=%b",
                         i, obs[16:3], obs[2], obs[1], obs[0], e[16:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_count_up();
        plan.delete();
        add(1, 0, 0, 1, 2'b00, 0,    0, 0, 0, 0);
        add(1, 0, 1, 0, 2'b00, 0,    0, 1, 0, 0);
        add(3, 0, 0, 0, 2'b00, 0,    0, 1, 0, 0);
        add(1, 0, 0, 0, 2'b00, 0,    1, 1, 0, 1);
        add(3, 0, 0, 0, 2'b00, 0,    1, 1, 0, 0);
        add(1, 0, 0, 0, 2'b00, 0,    2, 1, 0, 1);
        foreach (plan[i]) begin
            rst = plan[i].r; start_btn = plan[i].s; clear_btn = plan[i].c;
            mode = plan[i].m; load_val = plan[i].ld;
            sb.push_back(plan[i].exp);
            @(posedge clk); #1;
            e = sb.pop_front();
            obs = {count, running, at_limit, tick};
            cmp_count++;
            if (obs !== e) begin
                fail_count++;
                $display("[TB] FAIL count_up step %0d: got count=%0d running=%b at_limit=%b tick=%b, expected count=%0d running=%b at_limit=%b tick=%b",
                         i, obs[16:3], obs[2], obs[1], obs[0], e[16:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_limit_up();
        plan.delete();
        add(1, 0, 0, 1, 2'b00, 9997, 9997, 0, 0, 0);
        add(1, 0, 1, 0, 2'b00, 9997, 9997, 1, 0, 0);
        add(3, 0, 0, 0, 2'b00, 9997, 9997, 1, 0, 0);
        add(1, 0, 0, 0, 2'b00, 9997, 9998, 1, 0, 1);
        add(3, 0, 0, 0, 2'b00, 9997, 9998, 1, 0, 0);
        add(1, 0, 0, 0, 2'b00, 9997, 9999, 0, 1, 1);
        add(4, 0, 0, 0, 2'b00, 9997, 9999, 0, 1, 0);
        add(1, 0, 1, 0, 2'b00, 9997, 9999, 0, 1, 0);
        add(2, 0, 0, 0, 2'b00, 9997, 9999, 0, 1, 0);
        foreach (plan[i]) begin
            rst = plan[i].r; start_btn = plan[i].s; clear_btn = plan[i].c;
            mode = plan[i].m; load_val = plan[i].ld;
            sb.push_back(plan[i].exp);
            @(posedge clk); #1;
            e = sb.pop_front();
            obs = {count, running, at_limit, tick};
            cmp_count++;
            if (obs !== e) begin
                fail_count++;
                $display("[TB] FAIL limit_up step %0d: got count=%0d running=%b at_limit=%b tick=%b, expected count=%0d running=%b at_limit=%b tick=%b",
                         i, obs[16:3], obs[2], obs[1], obs[0], e[16:3], e[2], e[1], e[0]);
            end
        end
    endtask

    task automatic test_count_down();
        plan.delete();
        add(1, 0, 0, 1, 2'b10, 9999, 9999, 0, 0, 0);
        add(1, 0, 1, 0, 2'b10, 9999, 9999, 1, 0, 0);
        add(3, 0, 0, 0, 2'b10, 9999, 9999, 1, 0, 0);
        add(1, 0, 0, 0, 2'b10, 9999, 9998, 1, 0, 1);
        add(3, 0, 0, 0, 2'b10, 9999, 9998, 1, 0, 0);
        add(1, 0, 0, 0, 2'b10, 9999, 9997, 1, 0, 1);
        add(1, 0, 0, 1, 2'b11, 0,    0,    0, 0, 0);
        add(1, 0, 1, 0, 2'b11, 0,    0,    0, 1, 0);
        add(5, 0, 0, 0, 2'b11, 0,    0,    0, 1, 0);
        foreach (plan[i]) begin
            rst = plan[i].r; start_btn = plan[i].s; clear_btn = plan[i].c;
            mode = plan[i].m; load_val = plan[i].ld;
            sb.push_back(plan[i].exp);
            @(posedge clk); #1;
            e = sb.pop_front();
            obs = {count, running, at_limit, tick};
            cmp_count++;
            if (obs !== e) begin
                fail_count++;
                $display("[TB] FAIL count_down step %0d: got count=%0d running=%b at_limit=%b tick=%b, expected count=%0d running=%b at_limit=%b tick=%b",
                         i, obs[16:3], obs[2], obs[1], obs[0], e[16:3], e[2], e[1], e[0]);
            end
        end
    endtask

    // Pause with the prescaler at 2, hold 20 cycles, resume, then flip the
    // direction mid-run and expect the next step to go down.
    task automatic test_pause();
        plan.delete();
        add(1,  0, 0, 1, 2'b00, 5, 5, 0, 0, 0);
        add(1,  0, 1, 0, 2'b00, 5, 5, 1, 0, 0);
        add(2,  0, 0, 0, 2'b00, 5, 5, 1, 0, 0);
        add(1,  0, 1, 0, 2'b00, 5, 5, 0, 0, 0);
        add(20, 0, 0, 0, 2'b00, 5, 5, 0, 0, 0);
        add(1,  0, 1, 0, 2'b00, 5, 5, 1, 0, 0);
        add(1,  0, 0, 0, 2'b00, 5, 5, 1, 0, 0);
        add(1,  0, 0, 0, 2'b00, 5, 6, 1, 0, 1);
        add(3,  0, 0, 0, 2'b00, 5, 6, 1, 0, 0);
        add(1,  0, 0, 0, 2'b00, 5, 7, 1, 0, 1);
        add(3,  0, 0, 0, 2'b10, 5, 7, 1, 0, 0);
        add(1,  0, 0, 0, 2'b10, 5, 6, 1, 0, 1);
        foreach (plan[i]) begin
            rst = plan[i].r; start_btn = plan[i].s; clear_btn = plan[i].c;
            mode = plan[i].m; load_val = plan[i].ld;
            sb.push_back(plan[i].exp);
            @(posedge clk); #1;
            e = sb.pop_front();
            obs = {count, running, at_limit, tick};
            cmp_count++;
            if (obs !== e) begin
                fail_count++;
                $display("[TB] FAIL pause step %0d: got count=%0d running=%b at_limit=%b tick=%b, expected count=%0d running=%b at_limit=%b tick=%b",
                         i, obs[16:3], obs[2], obs[1], obs[0], e[16:3], e[2], e[1], e[0]);
            end
        end
    endtask

    // Start and clear pressed together while running, with an out-of-range
    // reload; then a start at the limit goes straight to DONE.
    task automatic test_back_to_back();
        plan.delete();
        add(1, 0, 1, 1, 2'b00, 12000, 9999, 0, 0, 0);
        add(3, 0, 0, 0, 2'b00, 12000, 9999, 0, 0, 0);
        add(1, 0, 1, 0, 2'b00, 12000, 9999, 0, 1, 0);
        add(2, 0, 0, 0, 2'b00, 12000, 9999, 0, 1, 0);
        foreach (plan[i]) begin
            rst = plan[i].r; start_btn = plan[i].s; clear_btn = plan[i].c;
            mode = plan[i].m; load_val = plan[i].ld;
            sb.push_back(plan[i].exp);
            @(posedge clk); #1;
            e = sb.pop_front();
            obs = {count, running, at_limit, tick};
            cmp_count++;
            if (obs !== e) begin
                fail_count++;
                $display("[TB] FAIL back_to_back step %0d: got count=%0d running=%b at_limit=%b tick=%b, expected count=%0d running=%b at_limit=%b tick=%b",
                         i, obs[16:3], obs[2], obs[1], obs[0], e[16:3], e[2], e[1], e[0]);
            end
        end
    endtask

    // Reset mid-prescale with start held high through release: nothing may
    // start until the button is released and pressed again.
    task automatic test_reset_mid_run();
        plan.delete();
        add(1, 0, 0, 1, 2'b00, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 2'b00, 0, 0, 1, 0, 0);
        add(2, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0);
        add(2, 1, 1, 0, 2'b00, 0, 0, 0, 0, 0);
        add(7, 0, 1, 0, 2'b00, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 2'b00, 0, 0, 1, 0, 0);
        add(3, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 2'b00, 0, 1, 1, 0, 1);
        foreach (plan[i]) begin
            rst = plan[i].r; start_btn = plan[i].s; clear_btn = plan[i].c;
            mode = plan[i].m; load_val = plan[i].ld;
            sb.push_back(plan[i].exp);
            @(posedge clk); #1;
            e = sb.pop_front();
            obs = {count, running, at_limit, tick};
            cmp_count++;
            if (obs !== e) begin
                fail_count++;
                $display("[TB] FAIL reset_mid_run step %0d: got count=%0d running=%b at_limit=%b tick=%b, expected count=%0d running=%b at_limit=%b tick=%b",
                         i, obs[16:3], obs[2], obs[1], obs[0], e[16:3], e[2], e[1], e[0]);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        start_btn = 1'b0;
        clear_btn = 1'b0;
        mode      = 2'b00;
        load_val  = 14'd0;

        test_reset();
        test_count_up();
        test_limit_up();
        test_count_down();
        test_pause();
        test_back_to_back();
        test_reset_mid_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule

// File: doc/stopwatch_count_ctrl.md
STOPWATCH_COUNT_CTRL -- requirements
Module: stopwatch_count_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000000, meaning clock cycles per count step (10 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter LIMIT_HI, default 9999, meaning upper count bound (display 99.99 s).
REQ-003 clk  in  1  system clock; all logic on its rising edge; one clock domain.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start_btn  in  1  debounced level; each rising edge is one start/stop request.
REQ-006 clear_btn  in  1  debounced level; each rising edge is one reload request.
REQ-007 mode  in  2  00 up from 0, 01 up from switches, 10 down from 9999, 11 down from switches; also drives the select of the upstream next/load mux.
REQ-008 next_val  in  14  upstream count+1 (mode[1]=0) or count-1 (mode[1]=1), combinational from count.
REQ-009 load_val  in  14  upstream reload value for the current mode.
REQ-010 count  out  14  registered current value; feeds the upstream mux operand.
REQ-011 running  out  1  high while state is RUN.
REQ-012 at_limit  out  1  high while state is DONE.
REQ-013 tick  out  1  one-cycle pulse on each prescaler wrap in RUN.

Function
REQ-014 Edge detect: start_edge = start_btn & ~start_q, clear_edge = clear_btn & ~clear_q; start_q/clear_q registered every cycle.
REQ-015 limit = LIMIT_HI when mode[1]=0, else 0; evaluated from current mode every cycle.
REQ-016 FSM states IDLE, RUN, PAUSE, DONE; encoding free.
REQ-017 clear_edge in any state: state->IDLE, count <= min(load_val, LIMIT_HI), prescaler <= 0, next cycle.
REQ-018 clear_edge has priority over start_edge and over tick in the same cycle.
REQ-019 start_edge in IDLE or PAUSE: if count == limit then state->DONE, else state->RUN.
REQ-020 start_edge in RUN: state->PAUSE; prescaler holds value; count holds.
REQ-021 start_edge in DONE: ignored.
REQ-022 Prescaler cleared to 0 on IDLE->RUN; counts 0..TICK_DIV-1 only in RUN; wraps to 0.
REQ-023 On wrap in RUN: tick=1 for that one cycle; if count == limit then state->DONE, count holds; else count <= next_val, and if next_val == limit then state->DONE same edge.
REQ-024 Count never leaves 0..LIMIT_HI; no wrap past 9999 or below 0 under any mode sequence.
REQ-025 Mode change during RUN/PAUSE takes effect at the next tick (direction and limit); count not reloaded.
REQ-026 Latency: start_edge to running=1 is 1 cycle; first count step occurs TICK_DIV cycles after entering RUN.
REQ-027 Outputs running, at_limit, tick, count all registered; no combinational path from inputs to outputs.

Reset
REQ-028 rst=1 at a clock edge: state=IDLE, count=0, prescaler=0, running=0, at_limit=0, tick=0, start_q=0, clear_q=0.
REQ-029 rst overrides all other inputs, including mid-RUN and mid-prescale; btn held high across reset release produces no edge.

Verification (TICK_DIV=4 in bench)
REQ-030 rst, mode=00, clear edge (load_val=0), start edge -> running=1 next cycle; count 1 after 4 cycles, 2 after 8; tick every 4th cycle.
REQ-031 mode=00, count loaded 9997, start -> counts 9998, 9999, then at_limit=1, running=0; further ticks/starts leave count=9999.
REQ-032 mode=10, load_val=9999, clear, start -> 9998, 9997...; preloaded 0 with mode=11 and start -> DONE in 1 cycle, count stays 0.
REQ-033 RUN at prescaler=2, start edge -> PAUSE, count frozen 20 cycles; start again -> next step after 1 more cycle (prescaler resumes at 2+1).
REQ-034 start_edge and clear_edge same cycle during RUN with load_val=12000 -> IDLE, count=9999, running=0.
REQ-035 rst asserted mid-RUN with start_btn held high -> all outputs zero; releasing rst with start_btn still high causes no RUN.
